// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a valid/ready load port.
// A loaded start value N counts down to zero. On reaching zero the block emits
// a one-cycle done pulse. In auto-reload mode it restarts from the last loaded
// value instead of stopping.
//
// Handshake: a load transfers on a rising edge where load_valid_i and
// load_ready_o are both high. load_ready_o depends only on the state, never on
// load_valid_i. A requester that raises valid keeps it raised, with a stable
// value, until the transfer happens. A value of 0 is a zero-length timer: it
// pulses done and stays idle.
module countdown_timer #(
  parameter int nb_bits = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_valid_i,
  input  logic [nb_bits-1:0] load_value_i,
  output logic               load_ready_o,
  input  logic               enable_i,
  input  logic               reload_i,
  input  logic               abort_i,
  output logic [nb_bits-1:0] count_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [nb_bits-1:0] ZERO = '0;
  localparam logic [nb_bits-1:0] ONE  = nb_bits'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [nb_bits-1:0] r_count;
  logic [nb_bits-1:0] w_count_next;
  logic [nb_bits-1:0] r_reload;
  logic [nb_bits-1:0] w_reload_next;
  logic               r_done;
  logic               w_done_next;
  logic               w_load_fire;

  assign load_ready_o = (r_state == IDLE);
  assign w_load_fire  = load_valid_i & load_ready_o;

  // State, count, reload value and done pulse register; reset clears all.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_count  <= ZERO;
      r_reload <= ZERO;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_done   <= w_done_next;
    end
  end

  // Next-state logic. In RUN the order of precedence is abort, then pause,
  // then decrement, then terminal count.
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_reload_next = r_reload;
    w_done_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load_fire) begin
          if (load_value_i != ZERO) begin
            w_count_next  = load_value_i;
            w_reload_next = load_value_i;
            w_state_next  = RUN;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          // Abort wins over a coincident terminal count, so no done pulse.
          w_count_next = ZERO;
          w_state_next = IDLE;
        end else if (enable_i) begin
          if (r_count > ONE) begin
            w_count_next = r_count - ONE;
          end else begin
            // Terminal count. RUN never holds 0, so this is count == 1.
            w_done_next = 1'b1;
            if (reload_i) begin
              w_count_next = r_reload;
            end else begin
              w_count_next = ZERO;
              w_state_next = IDLE;
            end
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = ZERO;
      end
    endcase
  end

  assign count_o = r_count;
  assign busy_o  = (r_state == RUN);
  assign done_o  = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (nb_bits = 4). Inputs are driven 1 time
// unit after each rising edge, and outputs are checked at the same point.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         load_ready;
  logic         enable;
  logic         reload;
  logic         abort_in;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int n_vec;
  int n_err;

  logic [W-1:0] exp_q[$];

  countdown_timer #(.nb_bits(W)) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .load_valid_i (load_valid),
    .load_value_i (load_value),
    .load_ready_o (load_ready),
    .enable_i     (enable),
    .reload_i     (reload),
    .abort_i      (abort_in),
    .count_o      (count),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs may be changed and outputs read after return.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a load for exactly one edge (the caller knows ready is high).
  task automatic do_load(input logic [W-1:0] v);
    load_valid = 1'b1;
    load_value = v;
    step();
    load_valid = 1'b0;
  endtask

  // Step once per queued expected count and check each value.
  task automatic run_counts(input string tag);
    while (exp_q.size() > 0) begin
      step();
      check(tag, 32'(count), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic check_flags(input string tag, input logic b, input logic d, input logic r);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_ready"}, 32'(load_ready), 32'(r));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    enable = 1'b1;
    reload = 1'b0;
    abort_in = 1'b0;

    // Reset for two cycles.
    step();
    step();
    check("rst_count", 32'(count), 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    step();

    // Basic: N=5 gives counts 5,4,3,2,1,0 and then a single done pulse.
    do_load(4'd5);
    check("basic_load", 32'(count), 32'd5);
    check_flags("basic_run", 1'b1, 1'b0, 1'b0);
    exp_q = '{4'd4, 4'd3, 4'd2, 4'd1};
    run_counts("basic_cnt");
    check("basic_done_prev", 32'(done), 32'd0);
    step();
    check("basic_zero", 32'(count), 32'd0);
    check_flags("basic_term", 1'b0, 1'b1, 1'b1);
    step();
    check("basic_done_once", 32'(done), 32'd0);

    // Pause: N=3 with enable 1,0,0,1,1 gives counts 2,2,2,1,0.
    do_load(4'd3);
    check("pause_load", 32'(count), 32'd3);
    enable = 1'b1; step(); check("pause_c1", 32'(count), 32'd2);
    enable = 1'b0; step(); check("pause_c2", 32'(count), 32'd2);
    check("pause_busy", 32'(busy), 32'd1);
    step(); check("pause_c3", 32'(count), 32'd2);
    check("pause_nodone", 32'(done), 32'd0);
    enable = 1'b1; step(); check("pause_c4", 32'(count), 32'd1);
    check("pause_nodone2", 32'(done), 32'd0);
    step(); check("pause_c5", 32'(count), 32'd0);
    check_flags("pause_term", 1'b0, 1'b1, 1'b1);
    step();
    check("pause_done_once", 32'(done), 32'd0);

    // Auto-reload: N=2 cycles 2,1,2,1,2,1,2 and pulses done on each 1->2.
    reload = 1'b1;
    do_load(4'd2);
    check("rl_load", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rl_one", 32'(count), 32'd1);
      check("rl_one_done", 32'(done), 32'd0);
      step();
      check("rl_two", 32'(count), 32'd2);
      check("rl_two_done", 32'(done), 32'd1);
      check("rl_busy", 32'(busy), 32'd1);
    end
    reload = 1'b0;
    step(); check("rl_end1", 32'(count), 32'd1);
    step(); check("rl_end0", 32'(count), 32'd0);
    check_flags("rl_term", 1'b0, 1'b1, 1'b1);
    step();

    // Abort on the terminal cycle: no done pulse.
    do_load(4'd1);
    check("ab1_load", 32'(count), 32'd1);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    check("ab1_count", 32'(count), 32'd0);
    check_flags("ab1", 1'b0, 1'b0, 1'b1);
    step();
    check("ab1_late_done", 32'(done), 32'd0);

    // Abort at count 2 with N=4.
    do_load(4'd4);
    exp_q = '{4'd3, 4'd2};
    run_counts("ab2_cnt");
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    check("ab2_count", 32'(count), 32'd0);
    check_flags("ab2", 1'b0, 1'b0, 1'b1);

    // Zero load: done pulses and the block never goes busy.
    do_load(4'd0);
    check("z_count", 32'(count), 32'd0);
    check_flags("z", 1'b0, 1'b1, 1'b1);
    step();
    check("z_after_done", 32'(done), 32'd0);
    check("z_after_busy", 32'(busy), 32'd0);

    // Max load: 15 enabled cycles to done, and no underflow afterwards.
    do_load(4'd15);
    check("max_load", 32'(count), 32'd15);
    for (int i = 14; i >= 1; i--) begin
      step();
      check("max_cnt", 32'(count), 32'(i));
      check("max_nodone", 32'(done), 32'd0);
    end
    step();
    check("max_zero", 32'(count), 32'd0);
    check_flags("max_term", 1'b0, 1'b1, 1'b1);
    step();
    check("max_hold0", 32'(count), 32'd0);
    check("max_done_once", 32'(done), 32'd0);

    // Reset mid-run while the count is paused at 7.
    enable = 1'b0;
    do_load(4'd7);
    step();
    check("rr_hold7", 32'(count), 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_count", 32'(count), 32'd0);
    check_flags("rr", 1'b0, 1'b0, 1'b1);
    enable = 1'b1;

    // A load held during RUN is ignored until the block is idle again.
    do_load(4'd3);
    load_valid = 1'b1;
    load_value = 4'd9;
    exp_q = '{4'd2, 4'd1, 4'd0};
    run_counts("ign_cnt");
    check("ign_term_done", 32'(done), 32'd1);
    check("ign_term_ready", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    check("ign_accept", 32'(count), 32'd9);
    check("ign_busy", 32'(busy), 32'd1);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    check("ign_abort", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
